// File: rtl/clk_ctrl_pkg.sv
// Shared types and constants for the BUFGMUX clock-select sequencer.
package clk_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        QUIESCE,
        SW0,
        SETTLE0,
        SW1,
        SETTLE1,
        RESUME
    } state_t;

    // Meaning of each S pin value
    localparam logic SEL_DIV2 = 1'b0;
    localparam logic SEL_CLK0 = 1'b1;
    localparam logic SEL_MUX0 = 1'b0;
    localparam logic SEL_CNT0 = 1'b1;

    localparam int SWITCH_COUNT_W = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sw_sync.sv
// Two-bit multi-flop synchroniser for the asynchronous switch request.
module sw_sync #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [1:0] RESET_VAL   = 2'b01
) (
    input  logic       clk0,
    input  logic       rst_n,
    input  logic [1:0] i_sw,
    output logic [1:0] o_sw_s
);

    logic [SYNC_STAGES-1:0][1:0] r_stages;

    // Resetting to the reset select keeps the FSM from seeing a phantom request
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            r_stages <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            r_stages <= {r_stages[SYNC_STAGES-2:0], i_sw};
        end
    end

    assign o_sw_s = r_stages[SYNC_STAGES-1];

endmodule

// File: rtl/clk_sel_sequencer.sv
// Debounces switch requests and walks the two BUFGMUX selects over, mux0 first,
// with downstream counters held off around each change.
module clk_sel_sequencer
    import clk_ctrl_pkg::*;
#(
    parameter int         SYNC_STAGES     = 2,
    parameter int         DEBOUNCE_CYCLES = 50000,
    parameter int         SETTLE_CYCLES   = 16,
    parameter logic [1:0] RESET_SEL       = 2'b01
) (
    input  logic                      clk0,
    input  logic                      rst_n,
    input  logic                      locked_i,
    input  logic [1:0]                sw_in_i,
    output logic                      sel_mux0_o,
    output logic                      sel_mux1_o,
    output logic                      cnt_en_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [SWITCH_COUNT_W-1:0] switch_count_o
);

    localparam int WAIT_W = $clog2(max_int(DEBOUNCE_CYCLES, SETTLE_CYCLES) + 1);
    localparam logic [WAIT_W-1:0] DEB_LAST = WAIT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WAIT_W-1:0] SET_LAST = WAIT_W'(SETTLE_CYCLES - 1);

    state_t                    r_state;
    logic [1:0]                r_cand;
    logic [WAIT_W-1:0]         r_wait;
    logic                      r_sel0;
    logic                      r_sel1;
    logic                      r_cnt_en;
    logic                      r_done;
    logic [SWITCH_COUNT_W-1:0] r_count;
    logic [1:0]                w_sw_s;
    logic [1:0]                w_cur_sel;

    sw_sync #(
        .SYNC_STAGES(SYNC_STAGES),
        .RESET_VAL  (RESET_SEL)
    ) u_sw_sync (
        .clk0  (clk0),
        .rst_n (rst_n),
        .i_sw  (sw_in_i),
        .o_sw_s(w_sw_s)
    );

    assign w_cur_sel = {r_sel1, r_sel0};

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cand   <= RESET_SEL;
            r_wait   <= '0;
            r_sel0   <= RESET_SEL[0];
            r_sel1   <= RESET_SEL[1];
            r_cnt_en <= 1'b1;
            r_done   <= 1'b0;
            r_count  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_sw_s != w_cur_sel && locked_i) begin
                        r_state <= DEBOUNCE;
                        r_cand  <= w_sw_s;
                        r_wait  <= '0;
                    end
                end
                // Lock loss beats everything; a changing input restarts the count
                DEBOUNCE: begin
                    if (!locked_i) begin
                        r_state <= IDLE;
                    end else if (w_sw_s != r_cand) begin
                        r_cand <= w_sw_s;
                        r_wait <= '0;
                    end else if (w_sw_s == w_cur_sel) begin
                        r_state <= IDLE;
                    end else if (r_wait == DEB_LAST) begin
                        r_state  <= QUIESCE;
                        r_wait   <= '0;
                        r_cnt_en <= 1'b0;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                QUIESCE: begin
                    if (r_wait == SET_LAST) begin
                        r_wait  <= '0;
                        r_state <= (r_cand[0] != r_sel0) ? SW0 : SW1;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                SW0: begin
                    r_sel0  <= r_cand[0];
                    r_wait  <= '0;
                    r_state <= SETTLE0;
                end
                SETTLE0: begin
                    if (r_wait == SET_LAST) begin
                        r_wait <= '0;
                        if (r_cand[1] != r_sel1) begin
                            r_state <= SW1;
                        end else begin
                            r_state  <= RESUME;
                            r_cnt_en <= 1'b1;
                            r_done   <= 1'b1;
                            r_count  <= r_count + SWITCH_COUNT_W'(1);
                        end
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                SW1: begin
                    r_sel1  <= r_cand[1];
                    r_wait  <= '0;
                    r_state <= SETTLE1;
                end
                SETTLE1: begin
                    if (r_wait == SET_LAST) begin
                        r_wait   <= '0;
                        r_state  <= RESUME;
                        r_cnt_en <= 1'b1;
                        r_done   <= 1'b1;
                        r_count  <= r_count + SWITCH_COUNT_W'(1);
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                RESUME: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign sel_mux0_o     = r_sel0;
    assign sel_mux1_o     = r_sel1;
    assign cnt_en_o       = r_cnt_en;
    assign done_o         = r_done;
    assign switch_count_o = r_count;
    assign busy_o         = (r_state != IDLE);

endmodule

// File: tb/tb_clk_sel_sequencer.sv
// Self-checking bench for clk_sel_sequencer: per-cycle outputs are compared
// against a timeline computed from the sequencing rules.
module tb_clk_sel_sequencer;

    localparam int         SYNC = 2;
    localparam int         D    = 4;
    localparam int         S    = 2;
    localparam logic [1:0] RSEL = 2'b01;

    logic       clk0     = 1'b0;
    logic       rst_n    = 1'b0;
    logic       locked_i = 1'b1;
    logic [1:0] sw_in_i  = RSEL;
    logic       sel_mux0_o;
    logic       sel_mux1_o;
    logic       cnt_en_o;
    logic       busy_o;
    logic       done_o;
    logic [7:0] switch_count_o;

    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;
    logic [1:0] modelSel;
    logic [7:0] modelCnt;

    clk_sel_sequencer #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(D),
        .SETTLE_CYCLES  (S),
        .RESET_SEL      (RSEL)
    ) dut (
        .clk0          (clk0),
        .rst_n         (rst_n),
        .locked_i      (locked_i),
        .sw_in_i       (sw_in_i),
        .sel_mux0_o    (sel_mux0_o),
        .sel_mux1_o    (sel_mux1_o),
        .cnt_en_o      (cnt_en_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .switch_count_o(switch_count_o)
    );

    always #5 clk0 = ~clk0;

    always @(posedge clk0) cyc <= cyc + 1;

    task automatic applyStimulus(input logic [1:0] sw, input logic lock);
        sw_in_i  = sw;
        locked_i = lock;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic checkAll(input bit chkBusy, input logic busyE, input logic cntEnE,
                            input logic sel0E, input logic sel1E, input logic doneE,
                            input logic [7:0] cntE);
        if (chkBusy) checkOutput("busy", 8'(busy_o), 8'(busyE));
        checkOutput("cnt_en", 8'(cnt_en_o), 8'(cntEnE));
        checkOutput("sel_mux0", 8'(sel_mux0_o), 8'(sel0E));
        checkOutput("sel_mux1", 8'(sel_mux1_o), 8'(sel1E));
        checkOutput("done", 8'(done_o), 8'(doneE));
        checkOutput("count", switch_count_o, cntE);
    endtask

    // Cycle at which RESUME is expected when busy rises at cycle b
    function automatic int endCycle(input int b, input logic [1:0] o, input logic [1:0] t);
        int r = b + D + S;
        if (o[0] != t[0]) r += 1 + S;
        if (o[1] != t[1]) r += 1 + S;
        return r;
    endfunction

    function automatic int sel1Cycle(input int b, input logic [1:0] o, input logic [1:0] t);
        return b + D + S + ((o[0] != t[0]) ? 1 + S : 0) + 1;
    endfunction

    function automatic logic [1:0] randTarget();
        logic [1:0] t;
        do t = 2'($urandom_range(0, 3)); while (t == modelSel);
        return t;
    endfunction

    task automatic checkIdle(input int n);
        repeat (n) begin
            @(negedge clk0);
            checkAll(1'b1, 1'b0, 1'b1, modelSel[0], modelSel[1], 1'b0, modelCnt);
        end
    endtask

    task automatic checkQuiet(input int n);
        repeat (n) begin
            @(negedge clk0);
            checkAll(1'b0, 1'b0, 1'b1, modelSel[0], modelSel[1], 1'b0, modelCnt);
        end
    endtask

    // Follows one sequence whose busy rises at cycle b, up to cycle lastCyc
    task automatic track(input int b, input logic [1:0] o, input logic [1:0] t,
                         input logic [7:0] oldCnt, input int lastCyc,
                         input int toggleCyc, input logic [1:0] toggleVal);
        int r  = endCycle(b, o, t);
        int t0 = b + D + S + 1;
        int t1 = sel1Cycle(b, o, t);
        int c;
        while (cyc < lastCyc) begin
            @(negedge clk0);
            c = cyc;
            checkAll(1'b1,
                     (c >= b) && (c <= r),
                     !((c >= b + D) && (c <= r - 1)),
                     ((o[0] != t[0]) && (c >= t0)) ? t[0] : o[0],
                     ((o[1] != t[1]) && (c >= t1)) ? t[1] : o[1],
                     (c == r),
                     (c >= r) ? oldCnt + 8'd1 : oldCnt);
            if (c == toggleCyc) applyStimulus(toggleVal, 1'b1);
        end
    endtask

    task automatic runSwitch(input logic [1:0] tgt);
        int b;
        checkIdle(int'($urandom_range(0, 3)));
        applyStimulus(tgt, 1'b1);
        b = cyc + 1 + SYNC;
        track(b, modelSel, tgt, modelCnt, endCycle(b, modelSel, tgt) + 2, -1, 2'b00);
        modelSel = tgt;
        modelCnt = modelCnt + 8'd1;
    endtask

    initial begin
        logic [1:0] tgt;
        logic [1:0] y;
        int         b;
        int         r;
        int         g;

        modelSel = RSEL;
        modelCnt = 8'd0;
        repeat (3) @(negedge clk0);
        checkAll(1'b1, 1'b0, 1'b1, RSEL[0], RSEL[1], 1'b0, 8'd0);
        rst_n = 1'b1;
        checkIdle(100);

        runSwitch(2'b00);
        runSwitch(2'b01);
        runSwitch(2'b10);
        repeat (4) runSwitch(randTarget());

        // Short glitches must be rejected without touching the selects
        repeat (4) begin
            g = int'($urandom_range(1, D - 1));
            applyStimulus(randTarget(), 1'b1);
            checkQuiet(g);
            applyStimulus(modelSel, 1'b1);
            checkQuiet(8);
            checkIdle(3);
        end

        // Input moves during SETTLE0: first sequence finishes, then a fresh one
        tgt = {modelSel[1], ~modelSel[0]};
        do y = 2'($urandom_range(0, 3)); while (y == tgt);
        applyStimulus(tgt, 1'b1);
        b = cyc + 1 + SYNC;
        r = endCycle(b, modelSel, tgt);
        track(b, modelSel, tgt, modelCnt, r + 1, b + D + S + 1, y);
        modelSel = tgt;
        modelCnt = modelCnt + 8'd1;
        b = r + 2;
        track(b, modelSel, y, modelCnt, endCycle(b, modelSel, y) + 2, -1, 2'b00);
        modelSel = y;
        modelCnt = modelCnt + 8'd1;

        // Pending request waits for lock
        tgt = randTarget();
        applyStimulus(tgt, 1'b0);
        checkIdle(int'($urandom_range(5, 15)));
        applyStimulus(tgt, 1'b1);
        b = cyc + 1;
        track(b, modelSel, tgt, modelCnt, endCycle(b, modelSel, tgt) + 2, -1, 2'b00);
        modelSel = tgt;
        modelCnt = modelCnt + 8'd1;

        // Lock lost mid-debounce aborts back to IDLE
        tgt = randTarget();
        applyStimulus(tgt, 1'b1);
        b = cyc + 1 + SYNC;
        track(b, modelSel, tgt, modelCnt, b + 1, -1, 2'b00);
        applyStimulus(tgt, 1'b0);
        checkIdle(6);
        applyStimulus(tgt, 1'b1);
        b = cyc + 1;
        track(b, modelSel, tgt, modelCnt, endCycle(b, modelSel, tgt) + 2, -1, 2'b00);
        modelSel = tgt;
        modelCnt = modelCnt + 8'd1;

        // Reset asserted in SETTLE1 takes effect without a clock
        tgt = {~modelSel[1], 1'($urandom_range(0, 1))};
        applyStimulus(tgt, 1'b1);
        b = cyc + 1 + SYNC;
        track(b, modelSel, tgt, modelCnt, sel1Cycle(b, modelSel, tgt), -1, 2'b00);
        rst_n = 1'b0;
        applyStimulus(RSEL, 1'b1);
        #1;
        checkOutput("rst_busy", 8'(busy_o), 8'd0);
        checkOutput("rst_cnt_en", 8'(cnt_en_o), 8'd1);
        checkOutput("rst_sel_mux0", 8'(sel_mux0_o), 8'(RSEL[0]));
        checkOutput("rst_sel_mux1", 8'(sel_mux1_o), 8'(RSEL[1]));
        checkOutput("rst_done", 8'(done_o), 8'd0);
        checkOutput("rst_count", switch_count_o, 8'd0);
        @(negedge clk0);
        rst_n    = 1'b1;
        modelSel = RSEL;
        modelCnt = 8'd0;
        checkIdle(5);

        // 256 completed sequences bring the counter back round to zero
        repeat (256) runSwitch(randTarget());
        checkOutput("wrap_count", switch_count_o, modelCnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
